// File: rtl/muldiv_if.sv
// Request/writeback bundle between the CPU control path and the iterative
// RV32M multiply/divide unit.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             kill;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [4:0]       rd_in;
   logic             busy;
   logic             done;
   logic             wb_write;
   logic [4:0]       wb_rd;
   logic [WIDTH-1:0] wb_data;

   modport master (
      output start, kill, funct3, operand_a, operand_b, rd_in,
      input  busy, done, wb_write, wb_rd, wb_data
   );

   modport slave (
      input  start, kill, funct3, operand_a, operand_b, rd_in,
      output busy, done, wb_write, wb_rd, wb_data
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up, one-cycle register-file writeback.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic     clock,
   input logic     reset,
   muldiv_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [5:0] LAST_STEP = 6'(WIDTH);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [5:0]       count_q, count_d;
   logic [2:0]       f3_q, f3_d;
   logic [4:0]       rd_q, rd_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] mb_q, mb_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic             neg_a_q, neg_a_d;
   logic             neg_b_q, neg_b_d;
   logic [WIDTH-1:0] wb_data_q, wb_data_d;

   logic             is_div, a_sgn, b_sgn, div_zero, overflow;
   logic [WIDTH:0]   add_sum, shl, sub;
   logic             take;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
      return n ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? ({(2*WIDTH){1'b0}} - v) : v;
   endfunction

   function automatic logic [WIDTH-1:0] fix_result(
      input logic [2:0]       f3,
      input logic [WIDTH:0]   acc,
      input logic [WIDTH-1:0] lo,
      input logic             na,
      input logic             nb
   );
      logic [2*WIDTH-1:0] prod;
      prod = cond_neg2({acc[WIDTH-1:0], lo}, na ^ nb);
      if (!f3[2])
         return (f3[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      else if (f3[1])
         return cond_neg(acc[WIDTH-1:0], na);
      else
         return cond_neg(lo, na ^ nb);
   endfunction

   // Signedness: MULH/DIV/REM both signed, MULHSU only a signed.
   assign is_div   = f3_q[2];
   assign a_sgn    = is_div ? ~f3_q[0] : (f3_q[1] ^ f3_q[0]);
   assign b_sgn    = is_div ? ~f3_q[0] : (f3_q[1:0] == 2'b01);
   assign div_zero = is_div && (mb_q == '0);
   assign overflow = is_div && !f3_q[0] && (lo_q == MIN_INT) && (mb_q == '1);

   assign add_sum = acc_q + (lo_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
   assign shl     = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign sub     = shl - {1'b0, mb_q};
   assign take    = (shl >= {1'b0, mb_q});

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      f3_d      = f3_q;
      rd_d      = rd_q;
      lo_d      = lo_q;
      mb_d      = mb_q;
      acc_d     = acc_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      wb_data_d = wb_data_q;
      if (bus.kill && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start && !bus.kill) begin
                  state_d = S_CALC;
                  count_d = '0;
                  f3_d    = bus.funct3;
                  rd_d    = bus.rd_in;
                  lo_d    = bus.operand_a;
                  mb_d    = bus.operand_b;
               end
            end
            S_CALC: begin
               // Count 0 turns the raw operands into magnitudes or takes a bypass.
               if (count_q == '0) begin
                  if (div_zero) begin
                     wb_data_d = f3_q[1] ? lo_q : '1;
                     state_d   = S_DONE;
                  end else if (overflow) begin
                     wb_data_d = f3_q[1] ? '0 : lo_q;
                     state_d   = S_DONE;
                  end else begin
                     neg_a_d = a_sgn & lo_q[WIDTH-1];
                     neg_b_d = b_sgn & mb_q[WIDTH-1];
                     lo_d    = cond_neg(lo_q, a_sgn & lo_q[WIDTH-1]);
                     mb_d    = cond_neg(mb_q, b_sgn & mb_q[WIDTH-1]);
                     acc_d   = '0;
                     count_d = 6'd1;
                  end
               end else begin
                  if (is_div) begin
                     acc_d = take ? sub : shl;
                     lo_d  = {lo_q[WIDTH-2:0], take};
                  end else begin
                     acc_d = {1'b0, add_sum[WIDTH:1]};
                     lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
                  end
                  count_d = count_q + 6'd1;
                  if (count_q == LAST_STEP) state_d = S_FIX;
               end
            end
            S_FIX: begin
               wb_data_d = fix_result(f3_q, acc_q, lo_q, neg_a_q, neg_b_q);
               state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         rd_q      <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rd_q      <= rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   always_ff @(posedge clock) begin
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
   end

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.wb_write = (state_q == S_DONE) && (rd_q != 5'd0);
   assign bus.wb_rd    = rd_q;
   assign bus.wb_data  = wb_data_q;
endmodule
